seg7_roll_monitor: RTL and testbench

//  Receive-side companion to the dice roller: reads a 7-segment bus plus decimal point (DP) from a dice-style display.

---
 rtl/seg7_roll_monitor_pkg.sv | 49 ++++
 rtl/seg7_roll_monitor_debounce.sv | 71 +++++++
 rtl/seg7_roll_monitor.sv | 137 +++++++++++++
 tb/tb_seg7_roll_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_roll_monitor_pkg.sv
// Shared definitions for the dice-display receive side: segment codes, FSM states
// and the pattern decoder used by seg7_roll_monitor.
package seg7_roll_monitor_pkg;

    // Segment order is {g,f,e,d,c,b,a}, 1 = lit.
    localparam logic [6:0] SEG_D0 = 7'b0111111;
    localparam logic [6:0] SEG_D1 = 7'b0000110;
    localparam logic [6:0] SEG_D2 = 7'b1011011;
    localparam logic [6:0] SEG_D3 = 7'b1001111;
    localparam logic [6:0] SEG_D4 = 7'b1100110;
    localparam logic [6:0] SEG_D5 = 7'b1101101;
    localparam logic [6:0] SEG_D6 = 7'b1111100;
    localparam logic [6:0] SEG_D7 = 7'b0000111;

    // Blank segments with DP lit is the "idle" display.
    localparam logic [7:0] BUS_RESET = {7'b0000000, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_REPORT  = 2'd2
    } state_e;

    typedef struct packed {
        logic       ok;
        logic [2:0] digit;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [6:0] seg);
        seg_dec_t r;
        r.ok = 1'b1;
        case (seg)
            SEG_D0:  r.digit = 3'd0;
            SEG_D1:  r.digit = 3'd1;
            SEG_D2:  r.digit = 3'd2;
            SEG_D3:  r.digit = 3'd3;
            SEG_D4:  r.digit = 3'd4;
            SEG_D5:  r.digit = 3'd5;
            SEG_D6:  r.digit = 3'd6;
            SEG_D7:  r.digit = 3'd7;
            default: begin
                r.ok    = 1'b0;
                r.digit = 3'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_roll_monitor_debounce.sv
// Synchronizer chain followed by a stability counter; the debounced register only
// takes a new value after it has been seen unchanged for STABLE_CYCLES edges.
module seg7_debounce #(
    parameter int            W             = 8,
    parameter int            SYNC_STAGES   = 2,
    parameter int            STABLE_CYCLES = 4,
    parameter logic [W-1:0]  RST_VAL       = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  sync_w;
    logic [W-1:0]  last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  db_q, db_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // cnt_q holds (edges seen unchanged - 2); the load edge is the STABLE_CYCLES-th.
    always_comb begin
        last_d = sync_w;
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync_w != last_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q == CNT_LOAD) begin
                db_d = sync_w;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= RST_VAL;
            cnt_q  <= '0;
            db_q   <= RST_VAL;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign dout_o = db_q;

endmodule

// File: rtl/seg7_roll_monitor.sv
// Receive-side monitor for the dice display: debounces the segment bus, decodes it,
// reports each finished roll and keeps saturating per-face and total counts.
module seg7_roll_monitor
    import seg7_roll_monitor_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [6:0]       seg_in,
    input  logic             dp_in,
    input  logic [2:0]       hist_sel,
    output logic [2:0]       digit_out,
    output logic             digit_ok,
    output logic             rolling,
    output logic             roll_valid,
    output logic [2:0]       roll_value,
    output logic             roll_err,
    output logic [CNT_W-1:0] hist_count,
    output logic [CNT_W-1:0] total_rolls
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [7:0]       bus_db;
    logic [6:0]       seg_db;
    logic             dp_db;
    seg_dec_t         dec;
    state_e           state_q, state_d;
    logic             report_en;
    logic             face_good;
    logic             valid_q, valid_d;
    logic [2:0]       value_q, value_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] hist_q [1:6];
    logic [CNT_W-1:0] hist_d [1:6];
    logic [CNT_W-1:0] total_q, total_d;

    // DP and segments share one debouncer so the DP rise and final face stay coherent.
    seg7_debounce #(
        .W             (8),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RST_VAL       (BUS_RESET)
    ) u_debounce (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .din_i  ({seg_in, dp_in}),
        .dout_o (bus_db)
    );

    assign seg_db    = bus_db[7:1];
    assign dp_db     = bus_db[0];
    assign dec       = seg_decode(seg_db);
    assign digit_out = dec.digit;
    assign digit_ok  = dec.ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!dp_db) state_d = ST_ROLLING;
            ST_ROLLING: if (dp_db)  state_d = ST_REPORT;
            ST_REPORT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rolling   = (state_q == ST_ROLLING);
    assign report_en = (state_q == ST_ROLLING) && (state_d == ST_REPORT);
    assign face_good = dec.ok && (dec.digit != 3'd0) && (dec.digit != 3'd7);

    always_comb begin
        valid_d = report_en;
        value_d = value_q;
        err_d   = err_q;
        total_d = total_q;
        hist_d  = hist_q;
        if (report_en) begin
            value_d = dec.digit;
            err_d   = !face_good;
            if (face_good) begin
                if (total_q != CNT_SAT) begin
                    total_d = total_q + CNT_W'(1);
                end
                for (int i = 1; i <= 6; i++) begin
                    if ((dec.digit == 3'(i)) && (hist_q[i] != CNT_SAT)) begin
                        hist_d[i] = hist_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            valid_q <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
            total_q <= '0;
            for (int i = 1; i <= 6; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            err_q   <= err_d;
            total_q <= total_d;
            hist_q  <= hist_d;
        end
    end

    // Faces 0 and 7 have no bin and read as zero.
    always_comb begin
        hist_count = '0;
        for (int i = 1; i <= 6; i++) begin
            if (hist_sel == 3'(i)) begin
                hist_count = hist_q[i];
            end
        end
    end

    assign roll_valid  = valid_q;
    assign roll_value  = value_q;
    assign roll_err    = err_q;
    assign total_rolls = total_q;

endmodule

// File: tb/tb_seg7_roll_monitor.sv
// Randomized scoreboard bench for seg7_roll_monitor; a 16-bit and a 2-bit counter
// instance share stimulus so saturation is exercised alongside normal counting.
module tb_seg7_roll_monitor;

    localparam int S  = 2;
    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'b0111111;
    logic       dp  = 1'b0;
    logic [2:0] hist_sel = 3'd0;

    logic [2:0]  a_digit, b_digit, a_value, b_value;
    logic        a_ok, b_ok, a_rolling, b_rolling, a_valid, b_valid, a_err, b_err;
    logic [15:0] a_hist, a_total;
    logic [1:0]  b_hist, b_total;

    seg7_roll_monitor #(.SYNC_STAGES(S), .STABLE_CYCLES(ST), .CNT_W(16)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .seg_in(seg), .dp_in(dp), .hist_sel(hist_sel),
        .digit_out(a_digit), .digit_ok(a_ok), .rolling(a_rolling), .roll_valid(a_valid),
        .roll_value(a_value), .roll_err(a_err), .hist_count(a_hist), .total_rolls(a_total)
    );

    seg7_roll_monitor #(.SYNC_STAGES(S), .STABLE_CYCLES(ST), .CNT_W(2)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .seg_in(seg), .dp_in(dp), .hist_sel(hist_sel),
        .digit_out(b_digit), .digit_ok(b_ok), .rolling(b_rolling), .roll_valid(b_valid),
        .roll_value(b_value), .roll_err(b_err), .hist_count(b_hist), .total_rolls(b_total)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: face table, expected-report queue and unbounded counts.
    logic [6:0] legal [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111};

    typedef struct {
        int value;
        bit err;
    } rep_t;

    rep_t q[$];
    int   hist_m [8];
    int   total_m = 0;

    function automatic int face_of(input logic [6:0] s);
        for (int i = 0; i < 8; i++) begin
            if (legal[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic int bin_exp(input logic [2:0] sel);
        if (sel == 3'd0 || sel == 3'd7) return 0;
        return hist_m[sel];
    endfunction

    // Monitor: pops an expected report on every roll_valid and tracks the counters.
    logic rst_edge = 1'b1;
    always @(posedge clk) rst_edge = rst;

    always @(negedge clk) begin : monitor
        rep_t r;
        if (rst_edge) begin
            for (int i = 0; i < 8; i++) hist_m[i] = 0;
            total_m = 0;
            q.delete();
            check("reset_valid", a_valid, 0);
        end else if (a_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_roll_valid actual=1 required=0 t=%0t", $time);
            end else begin
                r = q.pop_front();
                check("roll_value", a_value, r.value);
                check("roll_err", a_err, r.err);
                check("roll_value_b", b_value, r.value);
                check("roll_err_b", b_err, r.err);
                if (!r.err) begin
                    hist_m[r.value]++;
                    total_m++;
                end
            end
        end
        check("total_a", a_total, sat(total_m, 16));
        check("total_b", b_total, sat(total_m, 2));
        check("hist_a", a_hist, sat(bin_exp(hist_sel), 16));
        check("hist_b", b_hist, sat(bin_exp(hist_sel), 2));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] rand_legal();
        int idx;
        idx = $urandom_range(0, 7);
        return legal[idx];
    endfunction

    task automatic toggle_faces();
        int n;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            seg      = rand_legal();
            hist_sel = 3'($urandom_range(0, 7));
            tick($urandom_range(1, 5));
        end
    endtask

    task automatic start_roll();
        dp = 1'b0;
        tick(S + ST + 3);
        check("rolling_entered", a_rolling, 1);
        toggle_faces();
    endtask

    task automatic wait_rolling(input string name, input int budget);
        int k;
        k = 0;
        while (a_rolling !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, a_rolling, 1);
    endtask

    task automatic end_roll(input logic [6:0] fseg);
        rep_t r;
        int   f;
        seg = fseg;
        tick($urandom_range(0, 2));
        dp = 1'b1;
        f = face_of(fseg);
        r.value = (f < 0) ? 0 : f;
        r.err   = (f < 1) || (f > 6);
        q.push_back(r);
        tick(S + ST);
        check("valid_not_early", a_valid, 0);
        tick(1);
        check("valid_on_time", a_valid, 1);
        tick(1);
        check("valid_one_cycle", a_valid, 0);
        check("value_held", a_value, r.value);
        check("rolling_cleared", a_rolling, 0);
        check("digit_out", a_digit, r.value);
        check("digit_ok", a_ok, (f >= 0) ? 1 : 0);
        tick(2);
    endtask

    task automatic read_bin(input logic [2:0] sel, input int exp_a, input int exp_b);
        hist_sel = sel;
        #1;
        check("bin_read_a", a_hist, exp_a);
        check("bin_read_b", b_hist, exp_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a 0 face and DP low, then let the roll start on its own.
        @(posedge clk);
        #1;
        check("rst_digit", a_digit, 0);
        check("rst_ok", a_ok, 0);
        check("rst_rolling", a_rolling, 0);
        check("rst_valid_out", a_valid, 0);
        check("rst_value", a_value, 0);
        check("rst_err", a_err, 0);
        check("rst_total", a_total, 0);
        check("rst_hist", a_hist, 0);
        rst = 1'b0;
        tick(S + ST - 1);
        check("rolling_not_early", a_rolling, 0);
        wait_rolling("rolling_after_release", 4);
        seg = legal[2]; tick(3);
        seg = legal[4]; tick(3);
        seg = legal[6]; tick(3);
        end_roll(7'b1101101);
        read_bin(3'd5, 1, 1);
        check("total_after_clean", a_total, 1);

        // Short DP glitch must never start a roll.
        dp = 1'b0;
        tick(ST - 1);
        dp = 1'b1;
        for (int i = 0; i < S + ST + 6; i++) begin
            tick(1);
            check("glitch_rolling", a_rolling, 0);
        end
        check("glitch_total", a_total, 1);

        // Faces with no bin and an illegal pattern.
        start_roll();
        end_roll(7'b0000111);
        start_roll();
        end_roll(7'b1111111);
        check("bad_total", a_total, 1);

        // Five rolls on face 3 saturate the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            start_roll();
            end_roll(7'b1001111);
        end
        read_bin(3'd3, 5, 3);
        check("sat_total_b", b_total, 3);
        read_bin(3'd0, 0, 0);
        read_bin(3'd7, 0, 0);

        // Reset in the middle of a roll after building up face 2.
        for (int i = 0; i < 4; i++) begin
            start_roll();
            end_roll(7'b1011011);
        end
        read_bin(3'd2, 4, 3);
        start_roll();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        read_bin(3'd2, 0, 0);
        check("midrst_total", a_total, 0);
        check("midrst_rolling", a_rolling, 0);
        wait_rolling("rolling_after_midrst", S + ST + 4);
        end_roll(7'b1011011);
        read_bin(3'd2, 1, 1);

        // Random rolls, mostly legal faces with some garbage patterns.
        for (int i = 0; i < 20; i++) begin
            start_roll();
            if ($urandom_range(0, 3) == 0) end_roll(7'($urandom_range(0, 127)));
            else end_roll(rand_legal());
            hist_sel = 3'($urandom_range(0, 7));
        end

        tick(10);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
